// File: rtl/shot_game_sequencer_if.sv
// Host/scorer-facing signal bundle of the shot game sequencer.
// master: the side driving start/abort/score; slave: the sequencer itself.
interface shot_game_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] score;
  logic       score_en;
  logic       score_clr;
  logic [7:0] time_left;
  logic [7:0] lb1;
  logic [7:0] lb2;
  logic [7:0] lb3;
  logic [1:0] new_rank;
  logic [2:0] state;

  modport master (
    output start, abort, score,
    input  score_en, score_clr, time_left, lb1, lb2, lb3, new_rank, state
  );

  modport slave (
    input  start, abort, score,
    output score_en, score_clr, time_left, lb1, lb2, lb3, new_rank, state
  );
endinterface

// File: rtl/shot_game_sequencer.sv
// Round sequencer for the hoop-shot game: countdown, timed play window,
// top-3 leaderboard insertion and result display.
//
// state  | meaning
// IDLE   | waiting for start
// PRE    | pre-start countdown, scorer cleared on entry
// PLAY   | scorer enabled, play window counting down
// UPDATE | one cycle: insert round score into the leaderboard
// SHOW   | result display, new_rank held
module shot_game_sequencer #(
  parameter int TICK_CYCLES  = 50000000,
  parameter int PRE_SECONDS  = 3,
  parameter int GAME_SECONDS = 60,
  parameter int SHOW_SECONDS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  shot_game_sequencer_if.slave  bus
);
  localparam int            CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    PLAY   = 3'd2,
    UPDATE = 3'd3,
    SHOW   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [7:0]    sec_q, sec_d;
  logic          clr_q, clr_d;
  logic [1:0]    rank_q, rank_d;
  logic [7:0]    lb1_q, lb1_d, lb2_q, lb2_d, lb3_q, lb3_d;
  logic          tick, last_sec;

  assign tick     = (tick_q == TICK_LAST);
  assign last_sec = (sec_q == 8'd1);

  // State and datapath registers; synchronous reset clears everything, leaderboard included.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      sec_q   <= 8'd0;
      clr_q   <= 1'b0;
      rank_q  <= 2'd0;
      lb1_q   <= 8'd0;
      lb2_q   <= 8'd0;
      lb3_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      clr_q   <= clr_d;
      rank_q  <= rank_d;
      lb1_q   <= lb1_d;
      lb2_q   <= lb2_d;
      lb3_q   <= lb3_d;
    end
  end

  // Next-state, second countdown, leaderboard insertion and tick counter restart.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    clr_d   = 1'b0;
    rank_d  = rank_q;
    lb1_d   = lb1_q;
    lb2_d   = lb2_q;
    lb3_d   = lb3_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PRE;
          sec_d   = 8'(PRE_SECONDS);
          clr_d   = 1'b1;
          rank_d  = 2'd0;
        end
      end
      PRE: begin
        // abort wins over a coincident tick
        if (bus.abort) begin
          state_d = IDLE;
          sec_d   = 8'd0;
          rank_d  = 2'd0;
        end else if (tick) begin
          if (last_sec) begin
            state_d = PLAY;
            sec_d   = 8'(GAME_SECONDS);
          end else begin
            sec_d = sec_q - 8'd1;
          end
        end
      end
      PLAY: begin
        if (bus.abort) begin
          state_d = IDLE;
          sec_d   = 8'd0;
          rank_d  = 2'd0;
        end else if (tick) begin
          if (last_sec) begin
            state_d = UPDATE;
            sec_d   = 8'd0;
          end else begin
            sec_d = sec_q - 8'd1;
          end
        end
      end
      UPDATE: begin
        // strict compares: ties and zero never displace an entry
        if (bus.score > lb1_q) begin
          lb3_d  = lb2_q;
          lb2_d  = lb1_q;
          lb1_d  = bus.score;
          rank_d = 2'd1;
        end else if (bus.score > lb2_q) begin
          lb3_d  = lb2_q;
          lb2_d  = bus.score;
          rank_d = 2'd2;
        end else if (bus.score > lb3_q) begin
          lb3_d  = bus.score;
          rank_d = 2'd3;
        end else begin
          rank_d = 2'd0;
        end
        state_d = SHOW;
        sec_d   = 8'(SHOW_SECONDS);
      end
      SHOW: begin
        if (tick) begin
          if (last_sec) begin
            state_d = IDLE;
            sec_d   = 8'd0;
          end else begin
            sec_d = sec_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sec_d   = 8'd0;
      end
    endcase
    tick_d = ((state_d != state_q) || tick) ? '0 : tick_q + CW'(1);
  end

  assign bus.state     = state_q;
  assign bus.score_en  = (state_q == PLAY);
  assign bus.score_clr = clr_q;
  assign bus.time_left = ((state_q == PRE) || (state_q == PLAY)) ? sec_q : 8'd0;
  assign bus.new_rank  = rank_q;
  assign bus.lb1       = lb1_q;
  assign bus.lb2       = lb2_q;
  assign bus.lb3       = lb3_q;
endmodule

// File: tb/tb_shot_game_sequencer.sv
// Bench for shot_game_sequencer: phase/elapsed-cycle model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_shot_game_sequencer;
  localparam int T  = 4;
  localparam int PS = 2;
  localparam int GS = 5;
  localparam int SS = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   armed = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  shot_game_sequencer_if bus();

  shot_game_sequencer #(
    .TICK_CYCLES(T), .PRE_SECONDS(PS), .GAME_SECONDS(GS), .SHOW_SECONDS(SS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: phase 0..4 and cycles elapsed in that phase; leaderboard as a sorted list.
  int ph = 0;
  int cyc = 0;
  int m_lb[3] = '{0, 0, 0};
  int m_rank = 0;
  int pos;

  always @(posedge clock) begin
    if (reset) begin
      ph = 0; cyc = 0; m_rank = 0;
      m_lb = '{0, 0, 0};
    end else begin
      case (ph)
        0: if (bus.start) begin ph = 1; cyc = 0; m_rank = 0; end
        1: if (bus.abort) begin ph = 0; cyc = 0; m_rank = 0; end
           else if (cyc == PS * T - 1) begin ph = 2; cyc = 0; end
           else cyc++;
        2: if (bus.abort) begin ph = 0; cyc = 0; m_rank = 0; end
           else if (cyc == GS * T - 1) begin ph = 3; cyc = 0; end
           else cyc++;
        3: begin
          pos = 0;
          for (int i = 0; i < 3; i++) if (m_lb[i] >= int'(bus.score)) pos++;
          if (pos < 3) begin
            for (int j = 2; j > pos; j--) m_lb[j] = m_lb[j-1];
            m_lb[pos] = int'(bus.score);
            m_rank = pos + 1;
          end else begin
            m_rank = 0;
          end
          ph = 4; cyc = 0;
        end
        4: if (cyc == SS * T - 1) begin ph = 0; cyc = 0; end
           else cyc++;
        default: ph = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (armed) begin
      check("state", bus.state, ph);
      check("time_left", bus.time_left,
            (ph == 1) ? PS - cyc / T : (ph == 2) ? GS - cyc / T : 0);
      check("score_en", bus.score_en, (ph == 2) ? 1 : 0);
      check("score_clr", bus.score_clr, (ph == 1 && cyc == 0) ? 1 : 0);
      check("lb1", bus.lb1, m_lb[0]);
      check("lb2", bus.lb2, m_lb[1]);
      check("lb3", bus.lb3, m_lb[2]);
      check("new_rank", bus.new_rank, m_rank);
    end
  end

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    while (int'(bus.state) != s && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (int'(bus.state) != s) check("timeout_state", bus.state, s);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic check_lb(input string tag, input int e1, input int e2, input int e3, input int er);
    check({tag, "_lb1"}, bus.lb1, e1);
    check({tag, "_lb2"}, bus.lb2, e2);
    check({tag, "_lb3"}, bus.lb3, e3);
    check({tag, "_rank"}, bus.new_rank, er);
  endtask

  task automatic run_round(input int sc, input int e1, input int e2, input int e3, input int er);
    bus.score = 8'(sc);
    pulse_start();
    wait_state(4, 100);
    check_lb("round", e1, e2, e3, er);
    wait_state(0, 100);
  endtask

  int pre_tl[8] = '{2, 2, 2, 2, 1, 1, 1, 1};
  int rs[5] = '{7, 12, 8, 10, 0};
  int r1[5] = '{10, 12, 12, 12, 12};
  int r2[5] = '{7, 10, 10, 10, 10};
  int r3[5] = '{0, 7, 8, 10, 10};
  int rr[5] = '{2, 1, 3, 3, 0};
  int cnt;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.score = 8'd0;
    reset = 1'b1;
    @(negedge clock);
    armed = 1'b1;
    check("rst_state", bus.state, 0);
    check("rst_time_left", bus.time_left, 0);
    check("rst_en", bus.score_en, 0);
    check("rst_clr", bus.score_clr, 0);
    check_lb("rst", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);

    // full round timing, score 10
    bus.score = 8'd10;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check("pre_state", bus.state, 1);
      check("pre_tl", bus.time_left, pre_tl[i]);
      check("pre_clr", bus.score_clr, (i == 0) ? 1 : 0);
      @(negedge clock);
    end
    for (int i = 0; i < 20; i++) begin
      check("play_state", bus.state, 2);
      check("play_en", bus.score_en, 1);
      check("play_tl", bus.time_left, 5 - i / 4);
      @(negedge clock);
    end
    check("update_state", bus.state, 3);
    check("update_en", bus.score_en, 0);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      check("show_state", bus.state, 4);
      @(negedge clock);
    end
    check("idle_after_show", bus.state, 0);
    check_lb("r10", 10, 0, 0, 1);

    // leaderboard sequence
    for (int i = 0; i < 5; i++) run_round(rs[i], r1[i], r2[i], r3[i], rr[i]);

    // abort on PLAY cycle 6
    bus.score = 8'd50;
    pulse_start();
    wait_state(2, 100);
    repeat (5) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_play_state", bus.state, 0);
    check("abort_play_en", bus.score_en, 0);
    check("abort_play_tl", bus.time_left, 0);
    check_lb("abort_play", 12, 10, 10, 0);
    repeat (3) @(negedge clock);
    check("abort_play_lb1_later", bus.lb1, 12);

    // abort coinciding with the first PRE tick
    pulse_start();
    repeat (3) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_pre_state", bus.state, 0);
    check("abort_pre_tl", bus.time_left, 0);
    check_lb("abort_pre", 12, 10, 10, 0);
    repeat (2) @(negedge clock);

    // start held through a whole round
    bus.score = 8'd3;
    bus.start = 1'b1;
    wait_state(4, 100);
    cnt = 0;
    while (bus.state == 3'd4 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    check("show_len", cnt, 8);
    check("held_idle", bus.state, 0);
    @(negedge clock);
    check("held_restart_state", bus.state, 1);
    check("held_restart_clr", bus.score_clr, 1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("held_abort_state", bus.state, 0);
    @(negedge clock);

    // rebuild (12,10,8) from a fresh reset, then reset mid-PLAY
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_lb("rst2", 0, 0, 0, 0);
    run_round(12, 12, 0, 0, 1);
    run_round(10, 12, 10, 0, 2);
    run_round(8, 12, 10, 8, 3);
    bus.score = 8'd20;
    pulse_start();
    wait_state(2, 100);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_state", bus.state, 0);
    check("midrst_en", bus.score_en, 0);
    check("midrst_tl", bus.time_left, 0);
    check("midrst_clr", bus.score_clr, 0);
    check_lb("midrst", 0, 0, 0, 0);
    @(negedge clock);
    check("midrst_idle", bus.state, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shot_game_sequencer.md
Name: shot_game_sequencer

Overview:
- Top-level game controller for the hoop-shot scoring datapath.
- Sequences each round: pre-start countdown, timed play window, leaderboard update, result display.
- Drives the scorer's enable and clear inputs and keeps the top-3 leaderboard (lb1 highest).
- Leaderboard outputs feed the leaderboard seven-segment decoders directly.

Parameters:
- TICK_CYCLES, 50000000, clock cycles per one-second tick.
- PRE_SECONDS, 3, length of the pre-start countdown in ticks.
- GAME_SECONDS, 60, length of the play window in ticks (1..255).
- SHOW_SECONDS, 5, length of the result display in ticks.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state, including the leaderboard.
- start  in  1  level; starts a round when sampled high in IDLE.
- abort  in  1  level; cancels a round in PRE or PLAY.
- score  in  8  current round score from the scorer (unsigned).
- score_en  out  1  enable to the scorer; high only in PLAY.
- score_clr  out  1  one-cycle clear pulse to the scorer.
- time_left  out  8  seconds remaining in PRE or PLAY; 0 in all other states.
- lb1, lb2, lb3  out  8 each  leaderboard, lb1 >= lb2 >= lb3 always.
- new_rank  out  2  rank (1..3) taken by the last round; 0 = none.
- state  out  3  IDLE=0, PRE=1, PLAY=2, UPDATE=3, SHOW=4.

Behaviour:
- Reset value of every output and register is 0: state=IDLE, lb1..3, time_left, new_rank, score_en, score_clr, tick counter.
- Tick counter:
  - Cleared on every state entry.
  - Counts 0..TICK_CYCLES-1 and wraps.
  - The tick fires in the cycle where the counter equals TICK_CYCLES-1.
- IDLE: start=1 at an edge -> PRE next cycle. In that first PRE cycle: score_clr=1, time_left=PRE_SECONDS, new_rank=0.
- PRE:
  - Each tick decrements time_left.
  - A tick while time_left==1 -> PLAY, with time_left=GAME_SECONDS and score_en=1 from the first PLAY cycle.
  - PRE lasts exactly PRE_SECONDS*TICK_CYCLES cycles.
- PLAY:
  - Each tick decrements time_left.
  - A tick while time_left==1 -> UPDATE. score_en=0 from the UPDATE cycle onward.
  - PLAY lasts exactly GAME_SECONDS*TICK_CYCLES cycles.
- UPDATE: exactly one cycle. Samples score and inserts it using strict greater-than comparisons:
  - score > lb1: lb3<=lb2, lb2<=lb1, lb1<=score, new_rank=1.
  - else score > lb2: lb3<=lb2, lb2<=score, new_rank=2.
  - else score > lb3: lb3<=score, new_rank=3.
  - else: no change, new_rank=0.
  - A tie never displaces an existing entry. A score of 0 never enters.
  - Always -> SHOW.
- SHOW:
  - Lasts SHOW_SECONDS*TICK_CYCLES cycles, then -> IDLE.
  - new_rank is held through SHOW and IDLE until the next PRE entry.
- abort=1 in PRE or PLAY -> IDLE next cycle: score_en=0, time_left=0, no leaderboard update, new_rank=0.
- abort takes priority over a simultaneous tick.
- abort is ignored in IDLE, UPDATE and SHOW.
- start is ignored outside IDLE. start held high through SHOW begins a new round one cycle after entering IDLE.
- Arithmetic is unsigned 8-bit. time_left never wraps below 1 in PRE or PLAY.
- reset mid-round returns to the reset values on the next edge. The leaderboard is lost.

Test Plan:
All scenarios use TICK_CYCLES=4, PRE_SECONDS=2, GAME_SECONDS=5, SHOW_SECONDS=2.
- Full round timing: reset, then start pulse.
  - PRE for 8 cycles, with score_clr=1 only in PRE cycle 1 and time_left 2,2,2,2,1,1,1,1.
  - PLAY for 20 cycles with score_en=1 and time_left 5..1.
  - UPDATE for 1 cycle, SHOW for 8 cycles, then IDLE.
- Leaderboard sequence: round scores 10, 7, 12, 8, 10, 0 give:
  - 10 -> lb=(10,0,0), rank 1.
  - 7 -> (10,7,0), rank 2.
  - 12 -> (12,10,7), rank 1.
  - 8 -> (12,10,8), rank 3.
  - 10 (tie) -> (12,10,10), rank 3.
  - 0 -> unchanged, rank 0.
- Abort: abort on PLAY cycle 6 -> IDLE next cycle, score_en=0, time_left=0, lb unchanged, new_rank=0. The same applies to an abort coinciding with a tick in PRE.
- Start held continuously: new round enters PRE one cycle after SHOW->IDLE. start pulses during PRE, PLAY and SHOW have no effect.
- Reset mid-PLAY with lb=(12,10,8): next cycle state=IDLE and all outputs 0, including lb1..lb3.
